fmult_accum_mc: RTL and testbench
=================================

Name: fmult_accum_mc

Overview:
- Parametrised, sequential successor to the G.726 FMULT/accumulate stage.
- Computes the zero-predictor sum SEZ over NB taps and the full signal estimate SE over NB+NA taps using the G.726 floating-point FMULT.
- One tap per clock through a single shared FMULT datapath. Each request carries a channel tag, so one instance serves a time-multiplexed multi-channel codec.
- Sits between the predictor coefficient update (A/B coefficients, DQ/SR history) and the quantizer/reconstruction stages.

Parameters:
NB, 6, number of zero-predictor taps (B coefficients × DQ history); 1..8
NA, 2, number of pole-predictor taps (A coefficients × SR history); 0..4
CHW, 5, channel tag width (32 channels at default)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request strobe; accepted only when ready=1
ready  out  1  high when idle and able to accept start
ch_in  in  CHW  channel tag, latched with start
b_coef  in  NB*16  B coefficients, 16-bit two's complement, tap i at [16i+15:16i]
dq_hist  in  NB*11  DQ history, 11-bit float {sign, exp[3:0], mant[5:0]}, tap i at [11i+10:11i]
a_coef  in  NA*16  A coefficients, two's complement, same packing
sr_hist  in  NA*11  SR history, 11-bit float, same packing
done  out  1  one-cycle pulse; sez/se/ch_out valid
sez  out  15  SEZI[15:1]
se  out  15  SEI[15:1]
ch_out  out  CHW  tag of completed request

Behaviour:
- Reset: ready=1, done=0, sez=0, se=0, ch_out=0, accumulator=0, FSM=IDLE.
- Reset is effective on any cycle, including mid-operation: the request is aborted, no done is issued, and all outputs return to reset values.
- Start acceptance:
  - start && ready at edge k latches all coefficient/history inputs and ch_in; inputs may change afterwards.
  - ready=0 from k+1 until the done cycle.
  - start while ready=0 is ignored (no queueing).
- FSM: IDLE -> ZERO (NB cycles, taps B0..B_{NB-1}) -> POLE (NA cycles, A0..A_{NA-1}; skipped when NA=0) -> DONE (1 cycle) -> IDLE.
- Latency: done is high during cycle k+NB+NA+1. Default: done 9 cycles after the start edge.
- During the done cycle, ready is high, and a start in that cycle is accepted (back-to-back). Throughput is one request per NB+NA+1 cycles.
- At the ZERO->POLE transition, the accumulator value is captured as SEZI.
- sez, se and ch_out update only when done is asserted and hold until the next done.
- FMULT per tap (An 16-bit coefficient, SRn 11-bit float):
  - AnS = An[15].
  - AnMAG = AnS ? (16384 - (An>>2)) & 8191 : An>>2 (13 bits).
  - AnEXP = index of the MSB of AnMAG, plus 1 (0 if AnMAG=0).
  - AnMANT = AnMAG==0 ? 32 : (AnMAG<<6)>>AnEXP.
  - WEXP = SRnEXP + AnEXP (5 bits).
  - WMANT = (SRnMANT*AnMANT + 48)>>4 (8 bits).
  - WMAG = WEXP<=26 ? (WMANT<<7)>>(26-WEXP) : ((WMANT<<7)<<(WEXP-26)) & 32767.
  - WAn = (SRnS^AnS) ? (65536-WMAG) & 65535 : WMAG.
- Accumulation:
  - 16-bit two's-complement, wraps modulo 2^16 with no saturation.
  - Cleared when a start is accepted.
  - SEZI = sum of the B products; SEI = SEZI + sum of the A products.
  - When NA=0, SEI = SEZI.

Optional Feature:
FMULT_ACCUM_PIPE_EN
- Defined:
  - Adds a register between the FMULT result WAn and the accumulator.
  - Each tap's product is added one cycle later, and done moves to k+NB+NA+2.
  - ready timing shifts the same way.
  - Arithmetic results are identical.
- Undefined: single-cycle FMULT+add per tap, with the latency given in Behaviour.

Test Plan:
- All coefficients 0, all histories 0x000 -> every WAn=0; done at k+9, sez=0, se=0, ch_out=ch_in.
- B0=0x4000, DQ0=0x220 (exp 8, mant 32), all else 0 -> WB0=268; sez=134, se=134.
- Previous case plus A0=0x4000, SR0=0x220 -> sez=134, se=268.
- B0=0x4000/DQ0=0x220 and B1=0xC000/DQ1=0x220, rest 0 -> WB1=0xFEF4; SEZI wraps to 0; sez=0, se=0.
- Back-to-back requests with ch_in 3 then 17, plus a start issued while busy -> exactly two done pulses with ch_out 3 then 17; the busy-time start is dropped.
- reset asserted at k+4 of a request -> no done, sez/se/ch_out=0, ready=1 on the next cycle. Repeat with FMULT_ACCUM_PIPE_EN defined and check done at k+10.

Source files
------------

// File: rtl/fmult_accum_mc.sv
// Sequential G.726 FMULT/accumulate: SEZ over NB zero taps, SE over NB+NA taps, one tap per clock.
// Optional FMULT_ACCUM_PIPE_EN registers each product before it is accumulated (one extra cycle of latency).
module fmult_accum_mc #(
   parameter int NB  = 6,
   parameter int NA  = 2,
   parameter int CHW = 5
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   output logic                            ready,
   input  logic [CHW-1:0]                  ch_in,
   input  logic [NB*16-1:0]                b_coef,
   input  logic [NB*11-1:0]                dq_hist,
   input  logic [((NA > 0) ? NA : 1)*16-1:0] a_coef,
   input  logic [((NA > 0) ? NA : 1)*11-1:0] sr_hist,
   output logic                            done,
   output logic [14:0]                     sez,
   output logic [14:0]                     se,
   output logic [CHW-1:0]                  ch_out
);

   localparam int NAX = (NA > 0) ? NA : 1;
   localparam logic [3:0] NB_LAST = 4'(NB - 1);
   localparam logic [3:0] NA_LAST = 4'(NAX - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ZERO  = 3'd1;
   localparam logic [2:0] S_POLE  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
`ifdef FMULT_ACCUM_PIPE_EN
   localparam logic [2:0] S_TAIL  = S_DRAIN;
`else
   localparam logic [2:0] S_TAIL  = S_DONE;
`endif

   logic [2:0]        state_r, next_s;
   logic [3:0]        cnt_r;
   logic [NB*16-1:0]  b_r;
   logic [NB*11-1:0]  dq_r;
   logic [NAX*16-1:0] a_r;
   logic [NAX*11-1:0] sr_r;
   logic [CHW-1:0]    ch_r;
   logic [15:0]       acc_r, sezi_r, acc_next_s;
   logic [15:0]       an_s, w_s, add_w_s;
   logic [10:0]       srn_s;
   logic              iss_v_s, iss_lastz_s, iss_last_s;
   logic              add_v_s, add_lastz_s, add_last_s;

   // G.726 FMULT: 16-bit two's-complement coefficient times 11-bit float, result 16-bit two's complement
   function automatic logic [15:0] fmult(input logic [15:0] an, input logic [10:0] srn);
      logic        ans;
      logic [15:0] sh;
      logic [12:0] anmag;
      logic [3:0]  anexp;
      logic [18:0] mt;
      logic [5:0]  anmant;
      logic [4:0]  wexp;
      logic [11:0] prod;
      logic [7:0]  wmant;
      logic [14:0] base;
      logic [14:0] wmag;
      ans   = an[15];
      sh    = an >> 2'd2;
      anmag = ans ? (13'd0 - sh[12:0]) : sh[12:0];
      anexp = 4'd0;
      for (int i = 0; i < 13; i++) begin
         anexp = anmag[i] ? 4'(i + 1) : anexp;
      end
      mt     = {anmag, 6'd0} >> anexp;
      anmant = (anmag == 13'd0) ? 6'd32 : mt[5:0];
      wexp   = {1'b0, srn[9:6]} + {1'b0, anexp};
      prod   = 12'(srn[5:0]) * 12'(anmant) + 12'd48;
      wmant  = prod[11:4];
      base   = {wmant, 7'd0};
      wmag   = (wexp <= 5'd26) ? (base >> (5'd26 - wexp)) : (base << (wexp - 5'd26));
      return (srn[10] ^ ans) ? (16'd0 - {1'b0, wmag}) : {1'b0, wmag};
   endfunction

   // Next state and the operands of the tap being issued this cycle
   always_comb begin
      next_s      = state_r;
      iss_v_s     = 1'b0;
      iss_lastz_s = 1'b0;
      iss_last_s  = 1'b0;
      an_s        = b_r[15:0];
      srn_s       = dq_r[10:0];
      case (state_r)
         S_IDLE, S_DONE: begin
            if (start) next_s = S_ZERO;
            else       next_s = S_IDLE;
         end
         S_ZERO: begin
            iss_v_s = 1'b1;
            if (cnt_r == NB_LAST) begin
               iss_lastz_s = 1'b1;
               if (NA > 0) begin
                  next_s = S_POLE;
               end else begin
                  iss_last_s = 1'b1;
                  next_s     = S_TAIL;
               end
            end else begin
               next_s = S_ZERO;
            end
         end
         S_POLE: begin
            iss_v_s = 1'b1;
            an_s    = a_r[15:0];
            srn_s   = sr_r[10:0];
            if (cnt_r == NA_LAST) begin
               iss_last_s = 1'b1;
               next_s     = S_TAIL;
            end else begin
               next_s = S_POLE;
            end
         end
         S_DRAIN: next_s = S_DONE;
         default: next_s = S_IDLE;
      endcase
   end

   assign w_s = fmult(an_s, srn_s);

`ifdef FMULT_ACCUM_PIPE_EN
   logic        add_v_r, add_lastz_r, add_last_r;
   logic [15:0] add_w_r;

   // Product register between FMULT and the accumulator
   always_ff @(posedge clk) begin
      if (reset) begin
         add_v_r     <= 1'b0;
         add_lastz_r <= 1'b0;
         add_last_r  <= 1'b0;
         add_w_r     <= 16'd0;
      end else begin
         add_v_r     <= iss_v_s;
         add_lastz_r <= iss_lastz_s;
         add_last_r  <= iss_last_s;
         add_w_r     <= w_s;
      end
   end

   assign add_v_s     = add_v_r;
   assign add_lastz_s = add_lastz_r;
   assign add_last_s  = add_last_r;
   assign add_w_s     = add_w_r;
`else
   assign add_v_s     = iss_v_s;
   assign add_lastz_s = iss_lastz_s;
   assign add_last_s  = iss_last_s;
   assign add_w_s     = w_s;
`endif

   assign acc_next_s = acc_r + add_w_s;

   // Request latch, tap sequencing, modulo-2^16 accumulation and registered results
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
         cnt_r   <= 4'd0;
         b_r     <= {(NB*16){1'b0}};
         dq_r    <= {(NB*11){1'b0}};
         a_r     <= {(NAX*16){1'b0}};
         sr_r    <= {(NAX*11){1'b0}};
         ch_r    <= {CHW{1'b0}};
         acc_r   <= 16'd0;
         sezi_r  <= 16'd0;
         ready   <= 1'b1;
         done    <= 1'b0;
         sez     <= 15'd0;
         se      <= 15'd0;
         ch_out  <= {CHW{1'b0}};
      end else begin
         state_r <= next_s;
         ready   <= (next_s == S_IDLE) || (next_s == S_DONE);
         done    <= (next_s == S_DONE);
         if (start && ready) begin
            b_r   <= b_coef;
            dq_r  <= dq_hist;
            a_r   <= a_coef;
            sr_r  <= sr_hist;
            ch_r  <= ch_in;
            cnt_r <= 4'd0;
            acc_r <= 16'd0;
         end else begin
            // Operand registers shift so the current tap always sits in the low bits
            if (iss_v_s) begin
               cnt_r <= (iss_lastz_s || iss_last_s) ? 4'd0 : cnt_r + 4'd1;
               if (state_r == S_ZERO) begin
                  b_r  <= b_r >> 5'd16;
                  dq_r <= dq_r >> 4'd11;
               end else begin
                  a_r  <= a_r >> 5'd16;
                  sr_r <= sr_r >> 4'd11;
               end
            end
            if (add_v_s) acc_r <= acc_next_s;
         end
         if (add_v_s && add_lastz_s) sezi_r <= acc_next_s;
         if (add_v_s && add_last_s) begin
            se     <= acc_next_s[15:1];
            sez    <= add_lastz_s ? acc_next_s[15:1] : sezi_r[15:1];
            ch_out <= ch_r;
         end
      end
   end

endmodule

// File: tb/tb_fmult_accum_mc.sv
// Scoreboard bench for fmult_accum_mc: directed vectors, random requests against an arithmetic model, reset abort.
// Build with FMULT_ACCUM_PIPE_EN defined to check the pipelined latency.
module tb_fmult_accum_mc;
   localparam int NB  = 6;
   localparam int NA  = 2;
   localparam int CHW = 5;
   // done rises on edge k+LAT after the start edge k, i.e. it is high in cycle k+LAT+1
`ifdef FMULT_ACCUM_PIPE_EN
   localparam int LAT = NB + NA + 1;
`else
   localparam int LAT = NB + NA;
`endif

   logic              clk = 1'b0;
   logic              reset, start, ready, done;
   logic [CHW-1:0]    ch_in, ch_out;
   logic [NB*16-1:0]  b_coef;
   logic [NB*11-1:0]  dq_hist;
   logic [NA*16-1:0]  a_coef;
   logic [NA*11-1:0]  sr_hist;
   logic [14:0]       sez, se;

   fmult_accum_mc #(.NB(NB), .NA(NA), .CHW(CHW)) dut (
      .clk(clk), .reset(reset), .start(start), .ready(ready), .ch_in(ch_in),
      .b_coef(b_coef), .dq_hist(dq_hist), .a_coef(a_coef), .sr_hist(sr_hist),
      .done(done), .sez(sez), .se(se), .ch_out(ch_out));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int ch;
      int sez;
      int se;
      int at;
   } exp_t;
   exp_t sb[$];
   int hold_sez = 0, hold_se = 0, hold_ch = 0;

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference FMULT written straight from the arithmetic definition
   function automatic int fm(input int an, input int sr);
      int ans, mag, ex, mant, srs, sre, srm, wexp, wm, wmag;
      ans  = (an >> 15) & 1;
      mag  = ans ? ((16384 - (an >> 2)) & 8191) : (an >> 2);
      ex   = 0;
      for (int i = 0; i < 13; i++) if (((mag >> i) & 1) == 1) ex = i + 1;
      mant = (mag == 0) ? 32 : ((mag << 6) >> ex);
      srs  = (sr >> 10) & 1;
      sre  = (sr >> 6) & 15;
      srm  = sr & 63;
      wexp = sre + ex;
      wm   = (srm * mant + 48) >> 4;
      wmag = (wexp <= 26) ? ((wm << 7) >> (26 - wexp)) : (((wm << 7) << (wexp - 26)) & 32767);
      return ((srs ^ ans) != 0) ? ((65536 - wmag) & 65535) : wmag;
   endfunction

   function automatic void ref_sum(input logic [NB*16-1:0] bv, input logic [NB*11-1:0] dv,
                                   input logic [NA*16-1:0] av, input logic [NA*11-1:0] sv,
                                   output int esez, output int ese);
      int s;
      s = 0;
      for (int i = 0; i < NB; i++) s = (s + fm(int'(bv[16*i +: 16]), int'(dv[11*i +: 11]))) % 65536;
      esez = s >> 1;
      for (int i = 0; i < NA; i++) s = (s + fm(int'(av[16*i +: 16]), int'(sv[11*i +: 11]))) % 65536;
      ese = s >> 1;
   endfunction

   task automatic scramble();
      for (int i = 0; i < NB; i++) begin
         b_coef[16*i +: 16] = 16'($urandom());
         dq_hist[11*i +: 11] = 11'($urandom());
      end
      for (int i = 0; i < NA; i++) begin
         a_coef[16*i +: 16] = 16'($urandom());
         sr_hist[11*i +: 11] = 11'($urandom());
      end
      ch_in = CHW'($urandom());
   endtask

   // Called and returns at a negedge; waits for ready, issues one request, optionally queues its expectation
   task automatic issue(input int ch, input logic [NB*16-1:0] bv, input logic [NB*11-1:0] dv,
                        input logic [NA*16-1:0] av, input logic [NA*11-1:0] sv,
                        input bit push, input int esez, input int ese, output int k);
      exp_t e;
      int waited = 0;
      while (!ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("ready_before_start", int'(ready), 1);
      start = 1'b1; ch_in = CHW'(ch); b_coef = bv; dq_hist = dv; a_coef = av; sr_hist = sv;
      @(posedge clk);
      #1;
      k = cyc;
      if (push) begin
         e.ch = ch; e.sez = esez; e.se = ese; e.at = k + LAT;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      check("ready_low_when_busy", int'(ready), 0);
      scramble();
   endtask

   // Monitor: pops the scoreboard on each done and checks outputs hold between done pulses
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (reset) begin
            hold_sez = 0; hold_se = 0; hold_ch = 0;
         end else if (done) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_done: done=1 with no request outstanding (t=%0t)", $time);
            end else begin
               e = sb.pop_front();
               check("done_cycle", cyc, e.at);
               check("ch_out", int'(ch_out), e.ch);
               check("sez", int'(sez), e.sez);
               check("se", int'(se), e.se);
               hold_sez = e.sez; hold_se = e.se; hold_ch = e.ch;
            end
         end else begin
            check("sez_hold", int'(sez), hold_sez);
            check("se_hold", int'(se), hold_se);
            check("ch_out_hold", int'(ch_out), hold_ch);
         end
      end
   end

   logic [NB*16-1:0] bv;
   logic [NB*11-1:0] dv;
   logic [NA*16-1:0] av;
   logic [NA*11-1:0] sv;
   int k1, k2, esez, ese, waited;

   initial begin
      reset = 1'b1; start = 1'b0; ch_in = '0;
      b_coef = '0; dq_hist = '0; a_coef = '0; sr_hist = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", int'(ready), 1);
      check("rst_done", int'(done), 0);
      check("rst_sez", int'(sez), 0);
      check("rst_se", int'(se), 0);
      check("rst_ch_out", int'(ch_out), 0);
      reset = 1'b0;
      @(negedge clk);

      // all zero -> 0/0
      bv = '0; dv = '0; av = '0; sv = '0;
      issue(5, bv, dv, av, sv, 1'b1, 0, 0, k1);
      // single B tap: WB0 = 268
      bv[15:0] = 16'h4000; dv[10:0] = 11'h220;
      issue(1, bv, dv, av, sv, 1'b1, 134, 134, k1);
      // plus A0 of the same value
      av[15:0] = 16'h4000; sv[10:0] = 11'h220;
      issue(2, bv, dv, av, sv, 1'b1, 134, 268, k1);
      // +268 and -268 cancel to zero
      av = '0; sv = '0;
      bv[31:16] = 16'hC000; dv[21:11] = 11'h220;
      issue(4, bv, dv, av, sv, 1'b1, 0, 0, k1);

      // back-to-back with a dropped start while busy
      bv = '0; dv = '0; bv[15:0] = 16'h4000; dv[10:0] = 11'h220;
      issue(3, bv, dv, av, sv, 1'b1, 134, 134, k1);
      start = 1'b1; ch_in = CHW'(9);
      @(negedge clk);
      start = 1'b0;
      av[15:0] = 16'h4000; sv[10:0] = 11'h220;
      issue(17, bv, dv, av, sv, 1'b1, 134, 268, k2);
      check("b2b_spacing", k2 - k1, LAT + 1);

      // randomized requests against the model
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NB; i++) begin
            bv[16*i +: 16] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom());
            dv[11*i +: 11] = 11'($urandom());
         end
         for (int i = 0; i < NA; i++) begin
            av[16*i +: 16] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom());
            sv[11*i +: 11] = 11'($urandom());
         end
         ref_sum(bv, dv, av, sv, esez, ese);
         issue(int'($urandom_range(0, 31)), bv, dv, av, sv, 1'b1, esez, ese, k1);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      end

      // reset mid-request: the completed request's outputs are wiped, the aborted one never finishes
      bv = '0; dv = '0; av = '0; sv = '0;
      bv[15:0] = 16'h4000; dv[10:0] = 11'h220; av[15:0] = 16'h4000; sv[10:0] = 11'h220;
      issue(6, bv, dv, av, sv, 1'b1, 134, 268, k1);
      issue(11, bv, dv, av, sv, 1'b0, 0, 0, k2);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_ready", int'(ready), 1);
      check("abort_done", int'(done), 0);
      check("abort_sez", int'(sez), 0);
      check("abort_se", int'(se), 0);
      check("abort_ch_out", int'(ch_out), 0);
      repeat (20) @(negedge clk);

      // one more request after the abort
      issue(21, bv, dv, av, sv, 1'b1, 134, 268, k1);

      waited = 0;
      while (sb.size() != 0 && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
